i2d_operand_fwd_stage: RTL and testbench

//  Registered operand-select stage between decode and execute. Selects the A/B operands from

---
 rtl/i2d_operand_fwd_stage.sv | 96 +++++++++
 tb/tb_i2d_operand_fwd_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/i2d_operand_fwd_stage.sv
// rtl/i2d_operand_fwd_stage.sv - decode-to-execute operand select with result forwarding and hazard stall
module i2d_operand_fwd_stage #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int NFWD = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RW-1:0]        ra_addr,
    input  logic [RW-1:0]        rb_addr,
    input  logic [DW-1:0]        ra,
    input  logic [DW-1:0]        rb,
    input  logic [DW-1:0]        id_pc,
    input  logic [DW-1:0]        imm,
    input  logic [1:0]           sel_a,
    input  logic [1:0]           sel_b,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*RW-1:0]   fwd_addr,
    input  logic [NFWD*DW-1:0]   fwd_data,
    input  logic [NFWD-1:0]      fwd_pending,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        a,
    output logic [DW-1:0]        b,
    output logic                 hazard,
    output logic [CNTW-1:0]      hz_cnt
);

    logic [DW-1:0] fwd_a, fwd_b, next_a, next_b;
    logic          pend_a, pend_b, capture;

    // Scan oldest to youngest so the youngest matching stage overwrites last and wins.
    always_comb begin
        fwd_a  = ra;
        fwd_b  = rb;
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (ra_addr != '0 && fwd_valid[i] && fwd_addr[i*RW +: RW] == ra_addr) begin
                fwd_a  = fwd_data[i*DW +: DW];
                pend_a = fwd_pending[i];
            end
            if (rb_addr != '0 && fwd_valid[i] && fwd_addr[i*RW +: RW] == rb_addr) begin
                fwd_b  = fwd_data[i*DW +: DW];
                pend_b = fwd_pending[i];
            end
        end
    end

    always_comb begin
        case (sel_a)
            2'd0:    next_a = fwd_a;
            2'd1:    next_a = id_pc;
            default: next_a = '0;
        endcase
        case (sel_b)
            2'd0:    next_b = fwd_b;
            2'd1:    next_b = id_pc;
            2'd2:    next_b = imm;
            default: next_b = '0;
        endcase
    end

    assign hazard   = in_valid & (((sel_a == 2'd0) & pend_a) | ((sel_b == 2'd0) & pend_b));
    assign in_ready = flush | (~hazard & (~out_valid | out_ready));
    assign capture  = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            a         <= next_a;
            b         <= next_b;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hz_cnt <= '0;
        end else if (hazard && !flush && hz_cnt != {CNTW{1'b1}}) begin
            hz_cnt <= hz_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_i2d_operand_fwd_stage.sv
// tb/tb_i2d_operand_fwd_stage.sv - randomized model-checked bench for i2d_operand_fwd_stage
module tb_i2d_operand_fwd_stage;
    localparam int DW = 32, RW = 5, NFWD = 2, CNTW = 3;

    logic clk = 1'b0, rst, in_valid, in_ready, flush, out_valid, out_ready, hazard;
    logic [RW-1:0] ra_addr, rb_addr;
    logic [DW-1:0] ra, rb, id_pc, imm, a, b;
    logic [1:0] sel_a, sel_b;
    logic [NFWD-1:0] fwd_valid, fwd_pending;
    logic [NFWD*RW-1:0] fwd_addr;
    logic [NFWD*DW-1:0] fwd_data;
    logic [CNTW-1:0] hz_cnt;

    i2d_operand_fwd_stage #(.DW(DW), .RW(RW), .NFWD(NFWD), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra(ra), .rb(rb), .id_pc(id_pc), .imm(imm),
        .sel_a(sel_a), .sel_b(sel_b), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .fwd_pending(fwd_pending), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b),
        .hazard(hazard), .hz_cnt(hz_cnt));

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    bit m_valid;
    logic [DW-1:0] m_a, m_b;
    int m_cnt;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // First listed stage whose valid destination equals addr supplies the value.
    task automatic resolve(input logic [RW-1:0] addr, input logic [DW-1:0] rv,
                           output logic [DW-1:0] val, output bit hz);
        bit found = 0;
        val = rv;
        hz  = 0;
        if (addr != 0) begin
            for (int i = 0; i < NFWD; i++) begin
                if (!found && fwd_valid[i] && fwd_addr[i*RW +: RW] == addr) begin
                    found = 1;
                    val   = fwd_data[i*DW +: DW];
                    hz    = fwd_pending[i];
                end
            end
        end
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic step();
        logic [DW-1:0] va, vb, ea, eb;
        bit ha, hb, ehz, erdy;
        #1;
        resolve(ra_addr, ra, va, ha);
        resolve(rb_addr, rb, vb, hb);
        ea  = (sel_a == 0) ? va : (sel_a == 1) ? id_pc : '0;
        eb  = (sel_b == 0) ? vb : (sel_b == 1) ? id_pc : (sel_b == 2) ? imm : '0;
        ehz = in_valid && ((sel_a == 0 && ha) || (sel_b == 0 && hb));
        erdy = flush || (!ehz && (!m_valid || out_ready));
        check("hazard", hazard, ehz);
        check("in_ready", in_ready, erdy);
        @(posedge clk);
        #1;
        if (!rst) begin
            m_valid = 0; m_a = 0; m_b = 0; m_cnt = 0;
        end else begin
            if (ehz && !flush && m_cnt < (1 << CNTW) - 1) m_cnt++;
            if (flush) m_valid = 0;
            else if (in_valid && erdy) begin m_valid = 1; m_a = ea; m_b = eb; end
            else if (out_ready) m_valid = 0;
        end
        check("out_valid", out_valid, m_valid);
        check("a", a, m_a);
        check("b", b, m_b);
        check("hz_cnt", hz_cnt, m_cnt);
    endtask

    task automatic idle();
        rst = 1; in_valid = 0; flush = 0; out_ready = 1;
        ra_addr = 0; rb_addr = 0; ra = 0; rb = 0; id_pc = 0; imm = 0;
        sel_a = 0; sel_b = 0; fwd_valid = 0; fwd_addr = 0; fwd_data = 0; fwd_pending = 0;
    endtask

    task automatic randomize_inputs();
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 15) == 0);
        ra_addr = $urandom_range(0, 3); rb_addr = $urandom_range(0, 3);
        ra = $urandom; rb = $urandom; id_pc = $urandom; imm = $urandom;
        sel_a = $urandom_range(0, 3); sel_b = $urandom_range(0, 3);
        fwd_valid = $urandom; fwd_data = {$urandom, $urandom};
        for (int i = 0; i < NFWD; i++) begin
            fwd_addr[i*RW +: RW] = $urandom_range(0, 3);
            fwd_pending[i] = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        m_valid = 0; m_a = 0; m_b = 0; m_cnt = 0;
        // Reset with random inputs
        randomize_inputs(); rst = 0; step();
        randomize_inputs(); rst = 0; step();
        check("rst_out_valid", out_valid, 0);
        check("rst_a", a, 0);
        check("rst_hz_cnt", hz_cnt, 0);

        // Mux sources
        idle(); in_valid = 1; sel_a = 1; id_pc = 32'h100; sel_b = 2; imm = 32'hFFFF_FFF0;
        step();
        check("mux_a", a, 32'h100);
        check("mux_b", b, 32'hFFFF_FFF0);

        // Forwarding priority and address 0
        idle(); in_valid = 1; ra_addr = 5; ra = 32'h11; fwd_valid = 2'b11;
        fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hBB, 32'hAA};
        step();
        check("fwd_prio", a, 32'hAA);
        ra_addr = 0; fwd_addr = {5'd0, 5'd0};
        step();
        check("fwd_zero", a, 32'h11);

        // Hazard stall then release
        idle(); rst = 0; step();
        idle(); in_valid = 1; rb_addr = 7; fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd7};
        fwd_pending = 2'b01; out_ready = 0;
        for (int i = 0; i < 3; i++) step();
        check("hz_in_ready", in_ready, 0);
        check("hz_count3", hz_cnt, 3);
        fwd_pending = 0; fwd_data = {32'h0, 32'h55};
        step();
        check("hz_release_b", b, 32'h55);
        fwd_pending = 2'b01; sel_b = 2; out_ready = 1;
        step();
        check("hz_unselected", hazard, 0);

        // Back-pressure then simultaneous consume + capture
        idle(); in_valid = 1; sel_a = 1; id_pc = 32'h1234; step();
        out_ready = 0; id_pc = 32'h9999;
        for (int i = 0; i < 4; i++) step();
        check("bp_a_stable", a, 32'h1234);
        out_ready = 1; step();
        check("bp_new_a", a, 32'h9999);
        check("bp_valid", out_valid, 1);

        // Flush while holding a pair
        in_valid = 1; flush = 1; id_pc = 32'h7777; step();
        check("flush_valid", out_valid, 0);
        check("flush_a", a, 32'h9999);

        // Reset during a stall
        idle(); in_valid = 1; ra_addr = 3; fwd_valid = 2'b10; fwd_addr = {5'd3, 5'd0};
        fwd_pending = 2'b10; step(); step();
        rst = 0; step();
        check("midrst_valid", out_valid, 0);
        check("midrst_cnt", hz_cnt, 0);

        // Randomized traffic against the model (also drives hz_cnt into saturation)
        for (int n = 0; n < 600; n++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
